rpn_stack_calc: RTL
===================

// Module: rpn_stack_calc
// PURPOSE
//  Parametrised successor of the 8-deep keystroke calculator: an RPN calculator
//  with a DEPTH x W operand stack, signed add/sub/negate and stack-manipulation ops.
//  Sits between keypad decoder and display driver; one keystroke per valid/ready handshake.
//  Adds full/empty flags, error codes, a saturating mode and a backpressure handshake.
// PARAMETERS
//  W        8   operand/display width, two's complement
//  DEPTH    8   stack entries (>=2)
//  SATURATE 0   1: clamp arithmetic overflow to max/min, no error; 0: raise arith error
// PORTS
//  clk       in   1       clock, rising edge
//  rst_b     in   1       asynchronous active-low reset
//  key_valid in   1       keystroke present
//  key_op    in   4       0 NONE,1 NUMBER,2 PLUS,3 MINUS,4 EQUALS,5 NEGATE,6 LP,7 RP,8 CLEAR,9 DROP,10 SWAP,11 DUP
//  key_num   in   W       operand for NUMBER
//  key_ready out  1       block can accept a keystroke
//  display   out  W       registered top-of-stack (0 when empty)
//  depth     out  CW      entries in use, CW=$clog2(DEPTH+1)
//  empty     out  1       depth==0
//  full      out  1       depth==DEPTH
//  error     out  1       sticky error flag
//  err_code  out  2       0 none,1 underflow,2 stack overflow,3 arith overflow
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, depth=0, display=0, error=0, err_code=0;
//   key_ready=1 once rst_b released; in-flight op aborted, no partial stack write.
//  FSM: IDLE -> EXEC on accept (key_valid&key_ready); EXEC -> IDLE (ok) or ERR (fault);
//   ERR -> IDLE only on accepted CLEAR. key_ready = (state!=EXEC).
//  Latency: key accepted at edge N; stack, depth, display, error updated at edge N+1;
//   key_ready low during cycle after N, high again after N+1 (max 1 key / 2 cycles).
//  key_valid while key_ready=0: ignored; source holds it.
//  Ops (T=top, S=second, results replace operands, display<=new top):
//   NUMBER push key_num; DUP push T; DROP pop; SWAP exchange T,S;
//   PLUS S+T, MINUS S-T (pop 2 push 1); NEGATE -T in place;
//   EQUALS/LP/RP/NONE: no stack change, display refreshed; CLEAR: depth=0, display=0.
//  Underflow (err 1): binary/SWAP with depth<2; NEGATE/DROP/DUP with depth=0.
//  Stack overflow (err 2): NUMBER/DUP with full=1.
//  Arith overflow: signed result outside W bits, incl. NEGATE of -2^(W-1).
//   SATURATE=0 -> err 3; SATURATE=1 -> clamp to 2^(W-1)-1 / -2^(W-1), no error.
//  On any error: stack, depth, display unchanged; error=1, err_code set, state ERR.
//  In ERR: key_ready=1; all keys except CLEAR accepted and discarded (no effect);
//   CLEAR clears stack, error, err_code, display -> IDLE. err_code holds first fault.
//  DROP to empty: display=0. Depth never wraps; pointer arithmetic only on legal ops.
// TESTING (W=8, DEPTH=4)
//  NUM 5, NUM 3, MINUS -> display 0x02, depth 1, each result 1 cycle after accept.
//  NUM 1 x4, NUM 1 -> error=1, err_code=2, depth 4; NUM 9 ignored; CLEAR -> depth 0, error 0.
//  Empty stack, PLUS -> err_code=1, display 0; NEGATE after CLEAR on NUM 0x80 -> err_code=3.
//  SATURATE=1: NUM 0x7F, NUM 0x01, PLUS -> display 0x7F, error 0; NUM 0x80,NEGATE -> 0x7F.
//  NUM 4, NUM 7, SWAP -> display 4; DUP -> depth 3 display 4; DROP,DROP -> display 7.
//  key_valid held during EXEC counts once; rst_b low mid-EXEC -> depth 0, display 0, ready 1.

Source files
------------

// File: rtl/rpn_stack_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rpn_stack_calc : RPN keystroke calculator, DEPTH x W signed operand stack
// Rev 1.0
// ----------------------------------------------------------------------------
module rpn_stack_calc #(
   parameter int W        = 8,
   parameter int DEPTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       key_valid,
   input  logic [3:0]                 key_op,
   input  logic [W-1:0]               key_num,
   output logic                       key_ready,
   output logic [W-1:0]               display,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       empty,
   output logic                       full,
   output logic                       error,
   output logic [1:0]                 err_code
);

   localparam int CW    = $clog2(DEPTH+1);
   localparam int NSLOT = 1 << CW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam logic [3:0] OP_NUMBER = 4'd1;
   localparam logic [3:0] OP_PLUS   = 4'd2;
   localparam logic [3:0] OP_MINUS  = 4'd3;
   localparam logic [3:0] OP_NEGATE = 4'd5;
   localparam logic [3:0] OP_CLEAR  = 4'd8;
   localparam logic [3:0] OP_DROP   = 4'd9;
   localparam logic [3:0] OP_SWAP   = 4'd10;
   localparam logic [3:0] OP_DUP    = 4'd11;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_UNDER = 2'd1;
   localparam logic [1:0] ERR_OVER  = 2'd2;
   localparam logic [1:0] ERR_ARITH = 2'd3;

   localparam logic [W-1:0]  MAX_VAL    = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  MIN_VAL    = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0] FULL_DEPTH = CW'(DEPTH);

   logic [1:0]    state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [W-1:0]  num_q, num_d;
   logic [W-1:0]  stack_q [NSLOT];
   logic [W-1:0]  stack_d [NSLOT];
   logic [CW-1:0] depth_q, depth_d;
   logic [W-1:0]  display_q, display_d;
   logic          error_q, error_d;
   logic [1:0]    err_code_q, err_code_d;

   logic          accept;
   logic          fault;
   logic [1:0]    fault_code;
   logic [CW-1:0] top_idx, sec_idx;
   logic [W-1:0]  top_val, sec_val;
   logic          has1, has2, is_full;
   logic [W:0]    res_ext;
   logic [W:0]    neg_ext;

   // A W+1 bit signed result is out of range when its top two bits disagree.
   function automatic logic ovf(input logic [W:0] x);
      return x[W] ^ x[W-1];
   endfunction

   function automatic logic [W-1:0] clamp(input logic [W:0] x);
      if (ovf(x)) return x[W] ? MIN_VAL : MAX_VAL;
      return x[W-1:0];
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: begin
            if (error_q) state_d = (op_q == OP_CLEAR) ? ST_IDLE : ST_ERR;
            else         state_d = fault ? ST_ERR : ST_IDLE;
         end
         ST_ERR:  if (accept) state_d = ST_EXEC;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      key_ready = (state_q != ST_EXEC);
      accept    = key_valid && (state_q != ST_EXEC);
   end

   always_comb begin
      op_d  = accept ? key_op  : op_q;
      num_d = accept ? key_num : num_q;
   end

   always_comb begin
      top_idx = depth_q - CW'(1);
      sec_idx = depth_q - CW'(2);
      top_val = stack_q[top_idx];
      sec_val = stack_q[sec_idx];
      has1    = (depth_q != '0);
      has2    = (depth_q >= CW'(2));
      is_full = (depth_q == FULL_DEPTH);
      neg_ext = '0 - {top_val[W-1], top_val};
   end

   // Datapath: all stack/flag updates happen in the single EXEC cycle.
   always_comb begin
      stack_d    = stack_q;
      depth_d    = depth_q;
      display_d  = display_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      fault      = 1'b0;
      fault_code = ERR_NONE;
      res_ext    = '0;
      if (state_q == ST_EXEC) begin
         if (error_q) begin
            if (op_q == OP_CLEAR) begin
               depth_d    = '0;
               display_d  = '0;
               error_d    = 1'b0;
               err_code_d = ERR_NONE;
            end
         end else begin
            case (op_q)
               OP_NUMBER: begin
                  if (is_full) begin
                     fault = 1'b1; fault_code = ERR_OVER;
                  end else begin
                     stack_d[depth_q] = num_q;
                     depth_d          = depth_q + CW'(1);
                     display_d        = num_q;
                  end
               end
               OP_DUP: begin
                  if (!has1) begin
                     fault = 1'b1; fault_code = ERR_UNDER;
                  end else if (is_full) begin
                     fault = 1'b1; fault_code = ERR_OVER;
                  end else begin
                     stack_d[depth_q] = top_val;
                     depth_d          = depth_q + CW'(1);
                     display_d        = top_val;
                  end
               end
               OP_DROP: begin
                  if (!has1) begin
                     fault = 1'b1; fault_code = ERR_UNDER;
                  end else begin
                     depth_d   = depth_q - CW'(1);
                     display_d = has2 ? sec_val : '0;
                  end
               end
               OP_SWAP: begin
                  if (!has2) begin
                     fault = 1'b1; fault_code = ERR_UNDER;
                  end else begin
                     stack_d[top_idx] = sec_val;
                     stack_d[sec_idx] = top_val;
                     display_d        = sec_val;
                  end
               end
               OP_PLUS, OP_MINUS: begin
                  if (op_q == OP_PLUS) res_ext = {sec_val[W-1], sec_val} + {top_val[W-1], top_val};
                  else                 res_ext = {sec_val[W-1], sec_val} - {top_val[W-1], top_val};
                  if (!has2) begin
                     fault = 1'b1; fault_code = ERR_UNDER;
                  end else if (ovf(res_ext) && !SATURATE) begin
                     fault = 1'b1; fault_code = ERR_ARITH;
                  end else begin
                     stack_d[sec_idx] = clamp(res_ext);
                     depth_d          = depth_q - CW'(1);
                     display_d        = clamp(res_ext);
                  end
               end
               OP_NEGATE: begin
                  if (!has1) begin
                     fault = 1'b1; fault_code = ERR_UNDER;
                  end else if (ovf(neg_ext) && !SATURATE) begin
                     fault = 1'b1; fault_code = ERR_ARITH;
                  end else begin
                     stack_d[top_idx] = clamp(neg_ext);
                     display_d        = clamp(neg_ext);
                  end
               end
               OP_CLEAR: begin
                  depth_d   = '0;
                  display_d = '0;
               end
               default: display_d = has1 ? top_val : '0;
            endcase
            if (fault) begin
               error_d    = 1'b1;
               err_code_d = fault_code;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         op_q       <= '0;
         num_q      <= '0;
         depth_q    <= '0;
         display_q  <= '0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         for (int i = 0; i < NSLOT; i++) stack_q[i] <= '0;
      end else begin
         op_q       <= op_d;
         num_q      <= num_d;
         depth_q    <= depth_d;
         display_q  <= display_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         for (int i = 0; i < NSLOT; i++) stack_q[i] <= stack_d[i];
      end
   end

   assign display  = display_q;
   assign depth    = depth_q;
   assign empty    = (depth_q == '0);
   assign full     = is_full;
   assign error    = error_q;
   assign err_code = err_code_q;

endmodule
`default_nettype wire
